hci_cmd_queue: RTL and testbench

HCI_CMD_QUEUE -- requirements
Module: hci_cmd_queue

---
 rtl/hci_cmd_queue.sv | 163 ++++++++++++++++
 tb/tb_hci_cmd_queue.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hci_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : hci_cmd_queue
// Brief    : Register-mapped command FIFO feeding an HCI core, with result
//            capture and interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module hci_cmd_queue #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  reg_wr_en,
    input  logic [1:0]            reg_wr_addr,
    input  logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic                  reg_rd_en,
    input  logic [1:0]            reg_rd_addr,
    output logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic                  reg_rd_valid,
    output logic [DATA_WIDTH-1:0] cmd_tdata,
    output logic                  cmd_tvalid,
    input  logic                  cmd_tready,
    input  logic [DATA_WIDTH-1:0] res_tdata,
    input  logic                  res_tvalid,
    output logic                  irq
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_depth      = CW'(DEPTH);
    localparam logic [1:0]    c_addr_cmd    = 2'd0;
    localparam logic [1:0]    c_addr_ctrl   = 2'd1;
    localparam logic [1:0]    c_addr_status = 2'd2;
    localparam logic [1:0]    c_addr_result = 2'd3;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  enable_q, enable_d, irq_en_q, irq_en_d;
    logic                  overflow_q, overflow_d, pend_q, pend_d;
    logic [DATA_WIDTH-1:0] result_q, result_d, rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d, irq_q, irq_d;

    logic                  w_empty, w_full, w_pop, w_push;
    logic                  w_cmd_wr, w_ctrl_wr, w_flush;
    logic [DATA_WIDTH-1:0] w_status, w_rd_mux;

    assign w_empty    = (count_q == '0);
    assign w_full     = (count_q == c_depth);
    assign cmd_tvalid = enable_q && !w_empty;
    assign cmd_tdata  = mem_q[rd_ptr_q];
    assign w_pop      = cmd_tvalid && cmd_tready;
    assign w_cmd_wr   = reg_wr_en && (reg_wr_addr == c_addr_cmd);
    assign w_ctrl_wr  = reg_wr_en && (reg_wr_addr == c_addr_ctrl);
    assign w_flush    = w_ctrl_wr && reg_wr_data[1];
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push     = w_cmd_wr && (!w_full || w_pop);

    // STATUS layout needs DATA_WIDTH >= 12.
    always_comb begin
        w_status     = '0;
        w_status[7:0] = 8'(count_q);
        w_status[8]  = w_empty;
        w_status[9]  = w_full;
        w_status[10] = overflow_q;
        w_status[11] = pend_q;
    end

    always_comb begin
        w_rd_mux = '0;
        case (reg_rd_addr)
            c_addr_cmd:    w_rd_mux = w_empty ? '0 : mem_q[rd_ptr_q];
            c_addr_ctrl:   begin
                w_rd_mux[0] = enable_q;
                w_rd_mux[3] = irq_en_q;
            end
            c_addr_status: w_rd_mux = w_status;
            c_addr_result: w_rd_mux = result_q;
            default:       w_rd_mux = '0;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        overflow_d = overflow_q;
        pend_d     = pend_q;
        result_d   = result_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = reg_rd_en;
        irq_d      = irq_en_q && pend_q;

        if (w_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (w_push && !w_pop)      count_d = count_q + CW'(1);
            else if (!w_push && w_pop) count_d = count_q - CW'(1);
        end

        if (w_ctrl_wr) begin
            enable_d = reg_wr_data[0];
            irq_en_d = reg_wr_data[3];
            if (reg_wr_data[2]) overflow_d = 1'b0;
        end
        if (w_cmd_wr && !w_push) overflow_d = 1'b1;

        // New result wins over a same-cycle RESULT read so the pending flag survives.
        if (res_tvalid) begin
            result_d = res_tdata;
            pend_d   = 1'b1;
        end else if (reg_rd_en && (reg_rd_addr == c_addr_result)) begin
            pend_d   = 1'b0;
        end

        if (reg_rd_en) rd_data_d = w_rd_mux;
    end

    always_ff @(posedge ACLK) begin
        if (w_push) mem_q[wr_ptr_q] <= reg_wr_data;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            overflow_q <= 1'b0;
            pend_q     <= 1'b0;
            result_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            overflow_q <= overflow_d;
            pend_q     <= pend_d;
            result_q   <= result_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            irq_q      <= irq_d;
        end
    end

    assign reg_rd_data  = rd_data_q;
    assign reg_rd_valid = rd_valid_q;
    assign irq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_hci_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_hci_cmd_queue
// Brief    : Self-checking bench for hci_cmd_queue (vectors, directed
//            sequences, randomized traffic against a queue-based model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hci_cmd_queue;

    localparam int DEPTH = 8;
    localparam int DW    = 32;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          reg_wr_en = 1'b0;
    logic [1:0]    reg_wr_addr = 2'd0;
    logic [DW-1:0] reg_wr_data = '0;
    logic          reg_rd_en = 1'b0;
    logic [1:0]    reg_rd_addr = 2'd0;
    logic [DW-1:0] reg_rd_data;
    logic          reg_rd_valid;
    logic [DW-1:0] cmd_tdata;
    logic          cmd_tvalid;
    logic          cmd_tready = 1'b0;
    logic [DW-1:0] res_tdata = '0;
    logic          res_tvalid = 1'b0;
    logic          irq;

    hci_cmd_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
        .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
        .res_tdata(res_tdata), .res_tvalid(res_tvalid), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        wen;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic        ren;
        logic [1:0]  raddr;
        logic        exp_rv;
        logic [31:0] exp_rd;
        logic        exp_tv;
    } vec_t;

    vec_t tbl[12];

    // Reference model state: plain queue plus register flags
    logic [31:0] m_q[$];
    logic        m_en, m_ien, m_ovf, m_pend, m_rdv, m_irq;
    logic [31:0] m_res, m_rdd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = d;
        step();
        reg_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        reg_rd_en = 1'b1; reg_rd_addr = a;
        step();
        reg_rd_en = 1'b0;
        check({name, "_valid"}, 32'(reg_rd_valid), 32'd1);
        check(name, reg_rd_data, exp);
    endtask

    task automatic do_reset();
        reg_wr_en = 1'b0; reg_rd_en = 1'b0; res_tvalid = 1'b0; cmd_tready = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // {wen, waddr, wdata, ren, raddr, exp_rd_valid, exp_rd_data, exp_tvalid}
        tbl[0]  = '{1'b0, 2'd0, 32'h0,    1'b1, 2'd2, 1'b1, 32'h100, 1'b0};
        tbl[1]  = '{1'b1, 2'd0, 32'hA1,   1'b0, 2'd0, 1'b0, 32'h100, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 32'h0,    1'b1, 2'd2, 1'b1, 32'h001, 1'b0};
        tbl[3]  = '{1'b1, 2'd1, 32'h9,    1'b1, 2'd1, 1'b1, 32'h0,   1'b1};
        tbl[4]  = '{1'b0, 2'd0, 32'h0,    1'b1, 2'd1, 1'b1, 32'h9,   1'b1};
        tbl[5]  = '{1'b1, 2'd1, 32'hF,    1'b1, 2'd0, 1'b1, 32'hA1,  1'b0};
        tbl[6]  = '{1'b0, 2'd0, 32'h0,    1'b1, 2'd1, 1'b1, 32'h9,   1'b0};
        tbl[7]  = '{1'b0, 2'd0, 32'h0,    1'b1, 2'd0, 1'b1, 32'h0,   1'b0};
        tbl[8]  = '{1'b1, 2'd2, 32'hFFF,  1'b0, 2'd0, 1'b0, 32'h0,   1'b0};
        tbl[9]  = '{1'b0, 2'd0, 32'h0,    1'b1, 2'd2, 1'b1, 32'h100, 1'b0};
        tbl[10] = '{1'b1, 2'd3, 32'h1234, 1'b1, 2'd3, 1'b1, 32'h0,   1'b0};
        tbl[11] = '{1'b0, 2'd0, 32'h0,    1'b1, 2'd3, 1'b1, 32'h0,   1'b0};

        do_reset();
        check("reset_rd_valid", 32'(reg_rd_valid), 32'd0);
        check("reset_rd_data",  reg_rd_data,       32'd0);
        check("reset_tvalid",   32'(cmd_tvalid),   32'd0);
        check("reset_irq",      32'(irq),          32'd0);

        for (int i = 0; i < 12; i++) begin
            reg_wr_en = tbl[i].wen; reg_wr_addr = tbl[i].waddr; reg_wr_data = tbl[i].wdata;
            reg_rd_en = tbl[i].ren; reg_rd_addr = tbl[i].raddr;
            step();
            check($sformatf("vec%0d_rd_valid", i), 32'(reg_rd_valid), 32'(tbl[i].exp_rv));
            check($sformatf("vec%0d_rd_data", i),  reg_rd_data,       tbl[i].exp_rd);
            check($sformatf("vec%0d_tvalid", i),   32'(cmd_tvalid),   32'(tbl[i].exp_tv));
        end
        reg_wr_en = 1'b0; reg_rd_en = 1'b0;

        // Streaming: one push and one pop per cycle
        do_reset();
        wr(2'd1, 32'h1);
        cmd_tready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wr(2'd0, 32'(i));
            check($sformatf("stream_tvalid%0d", i), 32'(cmd_tvalid), 32'd1);
            check($sformatf("stream_tdata%0d", i),  cmd_tdata,       32'(i));
        end
        step();
        check("stream_drained_tvalid", 32'(cmd_tvalid), 32'd0);
        cmd_tready = 1'b0;
        rd(2'd2, 32'h100, "stream_status");

        // Overflow, overflow clear, ordered drain
        do_reset();
        for (int i = 0; i < 9; i++) wr(2'd0, 32'h10 + 32'(i));
        rd(2'd2, 32'h608, "ovf_status");
        wr(2'd1, 32'h4);
        rd(2'd2, 32'h208, "ovf_clr_status");
        cmd_tready = 1'b1;
        wr(2'd1, 32'h1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_tvalid%0d", i), 32'(cmd_tvalid), 32'd1);
            check($sformatf("drain_tdata%0d", i),  cmd_tdata,       32'h10 + 32'(i));
            step();
        end
        check("drain_9th_absent", 32'(cmd_tvalid), 32'd0);
        cmd_tready = 1'b0;

        // Push into a full FIFO while it pops
        do_reset();
        for (int i = 0; i < 8; i++) wr(2'd0, 32'h20 + 32'(i));
        wr(2'd1, 32'h1);
        reg_wr_en = 1'b1; reg_wr_addr = 2'd0; reg_wr_data = 32'h99; cmd_tready = 1'b1;
        step();
        reg_wr_en = 1'b0; cmd_tready = 1'b0;
        check("fullpush_head", cmd_tdata, 32'h21);
        rd(2'd2, 32'h208, "fullpush_status");

        // Backpressure stability, then flush
        do_reset();
        wr(2'd1, 32'h1);
        for (int i = 0; i < 3; i++) wr(2'd0, 32'h30 + 32'(i));
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall_tvalid%0d", i), 32'(cmd_tvalid), 32'd1);
            check($sformatf("stall_tdata%0d", i),  cmd_tdata,       32'h30);
        end
        wr(2'd1, 32'h2);
        check("flush_tvalid", 32'(cmd_tvalid), 32'd0);
        rd(2'd2, 32'h100, "flush_status");

        // Result capture and interrupt
        do_reset();
        wr(2'd1, 32'h9);
        res_tvalid = 1'b1; res_tdata = 32'hDEADBEEF;
        step();
        res_tvalid = 1'b0;
        step();
        check("irq_set", 32'(irq), 32'd1);
        rd(2'd3, 32'hDEADBEEF, "result_rd");
        step();
        check("irq_cleared", 32'(irq), 32'd0);
        reg_rd_en = 1'b1; reg_rd_addr = 2'd3; res_tvalid = 1'b1; res_tdata = 32'h5;
        step();
        reg_rd_en = 1'b0; res_tvalid = 1'b0;
        check("coincident_rd_old", reg_rd_data, 32'hDEADBEEF);
        step();
        check("coincident_irq", 32'(irq), 32'd1);
        rd(2'd2, 32'h900, "coincident_status");
        rd(2'd3, 32'h5, "result_new");

        // Asynchronous reset while commands are queued
        do_reset();
        wr(2'd1, 32'h1);
        for (int i = 0; i < 4; i++) wr(2'd0, 32'h40 + 32'(i));
        check("prereset_tvalid", 32'(cmd_tvalid), 32'd1);
        #2;
        ARESET = 1'b1;
        #1;
        check("async_reset_tvalid", 32'(cmd_tvalid), 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        step();
        check("postreset_tvalid", 32'(cmd_tvalid), 32'd0);
        rd(2'd2, 32'h100, "postreset_status");

        // Randomized traffic against the queue model
        do_reset();
        m_q.delete();
        m_en = 0; m_ien = 0; m_ovf = 0; m_pend = 0; m_rdv = 0; m_irq = 0;
        m_res = '0; m_rdd = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic        wen, ren, rdy, rv;
            logic [1:0]  wa, ra;
            logic [31:0] wd, rdat, rval;
            logic        pop, new_irq;
            int          sel;

            wen = ($urandom_range(0, 9) < 4);
            sel = $urandom_range(0, 19);
            wa  = (sel < 14) ? 2'd0 : (sel < 17) ? 2'd1 : 2'($urandom_range(2, 3));
            wd  = $urandom;
            if (wa == 2'd1) begin
                wd[0] = ($urandom_range(0, 9) < 8);
                wd[1] = ($urandom_range(0, 29) == 0);
            end
            ren  = ($urandom_range(0, 9) < 4);
            ra   = 2'($urandom_range(0, 3));
            rdy  = $urandom_range(0, 1) == 1;
            rv   = ($urandom_range(0, 9) == 0);
            rdat = $urandom;

            reg_wr_en = wen; reg_wr_addr = wa; reg_wr_data = wd;
            reg_rd_en = ren; reg_rd_addr = ra;
            cmd_tready = rdy; res_tvalid = rv; res_tdata = rdat;

            case (ra)
                2'd0: rval = (m_q.size() != 0) ? m_q[0] : 32'd0;
                2'd1: rval = {28'd0, m_ien, 2'b00, m_en};
                2'd2: begin
                    rval = 32'(m_q.size());
                    if (m_q.size() == 0)     rval = rval | 32'h100;
                    if (m_q.size() == DEPTH) rval = rval | 32'h200;
                    if (m_ovf)               rval = rval | 32'h400;
                    if (m_pend)              rval = rval | 32'h800;
                end
                default: rval = m_res;
            endcase

            pop     = m_en && (m_q.size() != 0) && rdy;
            new_irq = m_ien && m_pend;
            if (wen && wa == 2'd1 && wd[1]) begin
                m_q.delete();
            end else begin
                if (pop) void'(m_q.pop_front());
                if (wen && wa == 2'd0) begin
                    if (m_q.size() < DEPTH) m_q.push_back(wd);
                    else                    m_ovf = 1'b1;
                end
            end
            if (wen && wa == 2'd1) begin
                m_en  = wd[0];
                m_ien = wd[3];
                if (wd[2]) m_ovf = 1'b0;
            end
            if (rv) begin
                m_res  = rdat;
                m_pend = 1'b1;
            end else if (ren && ra == 2'd3) begin
                m_pend = 1'b0;
            end
            m_irq = new_irq;
            m_rdv = ren;
            if (ren) m_rdd = rval;

            step();
            check("rand_rd_valid", 32'(reg_rd_valid), 32'(m_rdv));
            check("rand_rd_data",  reg_rd_data,       m_rdd);
            check("rand_irq",      32'(irq),          32'(m_irq));
            check("rand_tvalid",   32'(cmd_tvalid),   32'(m_en && m_q.size() != 0));
            if (m_en && m_q.size() != 0) check("rand_tdata", cmd_tdata, m_q[0]);
        end
        reg_wr_en = 1'b0; reg_rd_en = 1'b0; res_tvalid = 1'b0; cmd_tready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
